operand_stack: RTL

- LIFO operand stack for the 8-bit multicycle stack CPU. It sits directly downstream of the unified instruction/data memory.
- PUSH loads the memory read data into the stack; POP supplies the write data back to memory.
- The ALU consumes the top two entries (tos, nos). The controller sequences push/pop strobes, one operation per cycle.

---
 rtl/operand_stack_if.sv | 20 ++
 rtl/operand_stack.sv | 58 +++++
 2 files changed

// File: rtl/operand_stack_if.sv
// operand_stack_if: push/pop strobes, push data and stack status for operand_stack.
// err_clr is present only when OPERAND_STACK_STICKY_ERR_EN is defined.
interface operand_stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   logic push, pop;
   logic [WIDTH-1:0] din, tos, nos;
   logic [CNT_W-1:0] count;
   logic empty, full, overflow, underflow;
`ifdef OPERAND_STACK_STICKY_ERR_EN
   logic err_clr;
   modport master(output push, pop, din, err_clr, input tos, nos, count, empty, full, overflow, underflow);
   modport slave(input push, pop, din, err_clr, output tos, nos, count, empty, full, overflow, underflow);
`else
   modport master(output push, pop, din, input tos, nos, count, empty, full, overflow, underflow);
   modport slave(input push, pop, din, output tos, nos, count, empty, full, overflow, underflow);
`endif
endinterface

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack feeding tos/nos to the ALU.
// Defining OPERAND_STACK_STICKY_ERR_EN makes overflow/underflow sticky until err_clr.
module operand_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input logic clk,
   input logic rst,
   operand_stack_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] stk [DEPTH];
   logic [CNT_W-1:0] sp;
   logic [AW-1:0] wr_idx;
   logic is_empty, is_full, inc, dec, wr_en, ov_evt, un_evt, ov, un;
   assign is_empty = sp == '0;
   assign is_full = sp == CNT_W'(DEPTH);
   // push+pop on a non-empty stack replaces the top in place; on an empty stack it is a plain push
   assign inc = bus.push && (bus.pop ? is_empty : !is_full);
   assign dec = bus.pop && !bus.push && !is_empty;
   assign wr_en = bus.push && (bus.pop || !is_full);
   assign wr_idx = (bus.pop && !is_empty) ? AW'(sp - 1'b1) : AW'(sp);
   assign ov_evt = bus.push && !bus.pop && is_full;
   assign un_evt = bus.pop && is_empty;
   assign bus.tos = is_empty ? '0 : stk[AW'(sp - 1'b1)];
   assign bus.nos = (sp < CNT_W'(2)) ? '0 : stk[AW'(sp - CNT_W'(2))];
   assign bus.count = sp;
   assign bus.empty = is_empty;
   assign bus.full = is_full;
   assign bus.overflow = ov;
   assign bus.underflow = un;
   // stack pointer, clamped to 0..DEPTH by the inc/dec qualification
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sp <= '0;
      else if (inc) sp <= sp + 1'b1;
      else if (dec) sp <= sp - 1'b1;
   end
   // storage is never cleared; writes are dropped while reset is held
   always_ff @(posedge clk) begin
      if (wr_en && !rst) stk[wr_idx] <= bus.din;
   end
   // error flags: one-cycle pulses, or sticky with set winning over err_clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov <= 1'b0;
         un <= 1'b0;
      end else begin
`ifdef OPERAND_STACK_STICKY_ERR_EN
         ov <= ov_evt || (ov && !bus.err_clr);
         un <= un_evt || (un && !bus.err_clr);
`else
         ov <= ov_evt;
         un <= un_evt;
`endif
      end
   end
endmodule
